// File: rtl/cache_control.sv
// cache_control: sequencing FSM for the 2-way set-associative LC-3b cache.
// Resolves hits in IDLE, writes back dirty victims, allocates lines from
// physical memory, drives every array strobe and keeps hit/miss counters.
//
// Handshakes: the CPU holds mem_read/mem_write until mem_resp (a one-cycle
// combinational pulse in IDLE); pmem_read/pmem_write are held continuously
// until and including the cycle pmem_resp=1, and are never high together.
module cache_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    input  logic        hit,
    input  logic        hit_way,
    input  logic        lru_out,
    input  logic        dirty1_out,
    input  logic        dirty2_out,
    input  logic        pmem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic        pmem_addr_sel,
    output logic        eviction,
    output logic        load_tag1,
    output logic        load_tag2,
    output logic        load_valid1,
    output logic        load_valid2,
    output logic        load_data1,
    output logic        load_data2,
    output logic        load_dirty1,
    output logic        load_dirty2,
    output logic        load_lru,
    output logic        data_sel,
    output logic        valid_in,
    output logic        dirty_in,
    output logic        lru_in,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   victim_q;
    logic   hit_event;
    logic   miss_event;
    logic   request;
    logic   is_write;
    logic   victim_dirty;

    // A simultaneous read and write is served as a read.
    assign request      = mem_read | mem_write;
    assign is_write     = mem_write & ~mem_read;
    assign victim_dirty = lru_out ? dirty2_out : dirty1_out;

    // State register and victim way latched at the start of a miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            victim_q <= 1'b0;
        end else begin
            state <= next_state;
            if (miss_event) begin
                victim_q <= lru_out;
            end
        end
    end

    // Next-state and strobe decode; everything is forced low while in reset.
    always_comb begin
        next_state    = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        eviction      = 1'b0;
        load_tag1     = 1'b0;
        load_tag2     = 1'b0;
        load_valid1   = 1'b0;
        load_valid2   = 1'b0;
        load_data1    = 1'b0;
        load_data2    = 1'b0;
        load_dirty1   = 1'b0;
        load_dirty2   = 1'b0;
        load_lru      = 1'b0;
        data_sel      = 1'b0;
        valid_in      = 1'b0;
        dirty_in      = 1'b0;
        lru_in        = 1'b0;
        hit_event     = 1'b0;
        miss_event    = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (request && hit) begin
                        mem_resp  = 1'b1;
                        load_lru  = 1'b1;
                        lru_in    = ~hit_way;
                        hit_event = 1'b1;
                        if (is_write) begin
                            load_data1  = ~hit_way;
                            load_data2  = hit_way;
                            load_dirty1 = ~hit_way;
                            load_dirty2 = hit_way;
                            dirty_in    = 1'b1;
                        end
                    end else if (request) begin
                        miss_event = 1'b1;
                        next_state = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    eviction      = 1'b1;
                    if (pmem_resp) begin
                        load_dirty1 = ~victim_q;
                        load_dirty2 = victim_q;
                        next_state  = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    eviction  = 1'b1;
                    if (pmem_resp) begin
                        load_data1  = ~victim_q;
                        load_data2  = victim_q;
                        load_tag1   = ~victim_q;
                        load_tag2   = victim_q;
                        load_valid1 = ~victim_q;
                        load_valid2 = victim_q;
                        load_dirty1 = ~victim_q;
                        load_dirty2 = victim_q;
                        data_sel    = 1'b1;
                        valid_in    = 1'b1;
                        next_state  = IDLE;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Saturating performance counters: one count per hit/miss event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if (hit_event && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_event && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed scenarios for cache_control. Each cycle's
// expected strobe vector is queued when the stimulus is applied and popped
// when the outputs are sampled on the falling edge.
module tb_cache_control;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic        mem_resp;
    logic        hit;
    logic        hit_way;
    logic        lru_out;
    logic        dirty1_out;
    logic        dirty2_out;
    logic        pmem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic        pmem_addr_sel;
    logic        eviction;
    logic        load_tag1;
    logic        load_tag2;
    logic        load_valid1;
    logic        load_valid2;
    logic        load_data1;
    logic        load_data2;
    logic        load_dirty1;
    logic        load_dirty2;
    logic        load_lru;
    logic        data_sel;
    logic        valid_in;
    logic        dirty_in;
    logic        lru_in;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic [17:0] obs;
    logic [17:0] exp_q[$];
    int          n_checks;
    int          n_errors;

    cache_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_resp      (mem_resp),
        .hit           (hit),
        .hit_way       (hit_way),
        .lru_out       (lru_out),
        .dirty1_out    (dirty1_out),
        .dirty2_out    (dirty2_out),
        .pmem_resp     (pmem_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_addr_sel (pmem_addr_sel),
        .eviction      (eviction),
        .load_tag1     (load_tag1),
        .load_tag2     (load_tag2),
        .load_valid1   (load_valid1),
        .load_valid2   (load_valid2),
        .load_data1    (load_data1),
        .load_data2    (load_data2),
        .load_dirty1   (load_dirty1),
        .load_dirty2   (load_dirty2),
        .load_lru      (load_lru),
        .data_sel      (data_sel),
        .valid_in      (valid_in),
        .dirty_in      (dirty_in),
        .lru_in        (lru_in),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    assign obs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, eviction,
                  load_tag1, load_tag2, load_valid1, load_valid2,
                  load_data1, load_data2, load_dirty1, load_dirty2,
                  load_lru, data_sel, valid_in, dirty_in, lru_in};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Expected strobe vectors in the same bit order as obs.
    function automatic logic [17:0] mk(input logic mr, pr, pw, as, ev,
                                       lt1, lt2, lv1, lv2, ld1, ld2, ly1, ly2,
                                       ll, ds, vi, di, li);
        return {mr, pr, pw, as, ev, lt1, lt2, lv1, lv2, ld1, ld2, ly1, ly2,
                ll, ds, vi, di, li};
    endfunction

    function automatic logic [17:0] v_hit(input logic way, input logic wr);
        logic w1;
        logic w2;
        w1 = wr & ~way;
        w2 = wr & way;
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, w1, w2, w1, w2, 1, 0, 0, wr, ~way);
    endfunction

    function automatic logic [17:0] v_wb(input logic resp, input logic vic);
        return mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, resp & ~vic, resp & vic,
                  0, 0, 0, 0, 0);
    endfunction

    function automatic logic [17:0] v_alloc(input logic resp, input logic vic);
        logic a1;
        logic a2;
        a1 = resp & ~vic;
        a2 = resp & vic;
        return mk(0, 1, 0, 0, 1, a1, a2, a1, a2, a1, a2, a1, a2, 0, resp, resp, 0, 0);
    endfunction

    // Called just after a rising edge: apply one cycle of inputs, queue the
    // expected strobes, compare on the falling edge, return after next edge.
    task automatic drive(input string tag, input logic rd, wr, h, hw, lru, d1, d2, pr,
                         input logic [17:0] e);
        mem_read   = rd;
        mem_write  = wr;
        hit        = h;
        hit_way    = hw;
        lru_out    = lru;
        dirty1_out = d1;
        dirty2_out = d2;
        pmem_resp  = pr;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            check_val(tag, {14'd0, obs}, {14'd0, exp_q.pop_front()});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag, input logic [15:0] h, input logic [15:0] m);
        check_val({tag, "_hits"}, {16'd0, hit_count}, {16'd0, h});
        check_val({tag, "_misses"}, {16'd0, miss_count}, {16'd0, m});
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        hit        = 1'b1;
        hit_way    = 1'b0;
        lru_out    = 1'b0;
        dirty1_out = 1'b0;
        dirty2_out = 1'b0;
        pmem_resp  = 1'b0;

        // Reset: outputs low even with a hitting request presented.
        #2;
        check_val("reset_outputs", {14'd0, obs}, 32'd0);
        check_counts("reset", 16'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean miss on an empty cache, pmem answers in the third ALLOCATE cycle.
        drive("miss_idle",    1, 0, 0, 0, 0, 0, 0, 0, 18'd0);
        check_counts("first_miss", 16'd0, 16'd1);
        drive("alloc_wait1",  1, 0, 0, 0, 0, 0, 0, 0, v_alloc(0, 0));
        drive("alloc_wait2",  1, 0, 0, 0, 0, 0, 0, 0, v_alloc(0, 0));
        drive("alloc_resp",   1, 0, 0, 0, 0, 0, 0, 1, v_alloc(1, 0));
        drive("refill_hit",   1, 0, 1, 0, 1, 0, 0, 0, v_hit(0, 0));
        check_counts("after_refill", 16'd1, 16'd1);

        // Read hit on way2, write hit on way1, read+write treated as read.
        drive("read_hit_w2",  1, 0, 1, 1, 0, 0, 0, 0, v_hit(1, 0));
        drive("write_hit_w1", 0, 1, 1, 0, 0, 0, 0, 0, v_hit(0, 1));
        drive("rdwr_hit_w2",  1, 1, 1, 1, 0, 1, 0, 0, v_hit(1, 0));
        drive("no_request",   0, 0, 1, 1, 1, 1, 1, 1, 18'd0);
        check_counts("after_hits", 16'd4, 16'd1);

        // Dirty miss on way2 with immediate pmem_resp; lru_out flips after the
        // miss is taken, so the victim must come from the latched copy.
        drive("dmiss_idle",   1, 0, 0, 0, 1, 0, 1, 0, 18'd0);
        check_counts("dirty_miss", 16'd4, 16'd2);
        drive("wb_resp",      1, 0, 0, 0, 0, 0, 1, 1, v_wb(1, 1));
        drive("alloc2_resp",  1, 0, 0, 0, 0, 0, 0, 1, v_alloc(1, 1));
        drive("dmiss_hit",    1, 0, 1, 1, 0, 0, 0, 0, v_hit(1, 0));
        check_counts("after_dmiss", 16'd5, 16'd2);

        // Clean victim selected by lru_out even though the other way is dirty.
        drive("cmiss_idle",   0, 1, 0, 0, 1, 1, 0, 0, 18'd0);
        drive("cmiss_alloc",  0, 1, 0, 0, 0, 1, 0, 1, v_alloc(1, 1));
        drive("cmiss_hit",    0, 1, 1, 1, 0, 1, 0, 0, v_hit(1, 1));
        check_counts("after_cmiss", 16'd6, 16'd3);

        // Dirty miss on way1, request dropped during WRITEBACK: the pmem
        // transaction still completes and no mem_resp follows.
        drive("drop_idle",    1, 0, 0, 0, 0, 1, 0, 0, 18'd0);
        drive("drop_wb_wait", 0, 0, 0, 0, 1, 1, 1, 0, v_wb(0, 0));
        drive("drop_wb_resp", 0, 0, 0, 0, 1, 1, 1, 1, v_wb(1, 0));
        drive("drop_alloc_w", 0, 0, 0, 0, 1, 1, 1, 0, v_alloc(0, 0));
        drive("drop_alloc_r", 0, 0, 0, 0, 1, 1, 1, 1, v_alloc(1, 0));
        drive("drop_idle2",   0, 0, 1, 0, 1, 1, 1, 0, 18'd0);
        check_counts("after_drop", 16'd6, 16'd4);

        // Reset pulse mid-ALLOCATE: pmem_read drops at once, counters clear,
        // and the held request restarts as a fresh miss.
        drive("rst_miss",     1, 0, 0, 0, 0, 0, 0, 0, 18'd0);
        drive("rst_alloc",    1, 0, 0, 0, 0, 0, 0, 0, v_alloc(0, 0));
        rst_n = 1'b0;
        #1;
        check_val("rst_async_outputs", {14'd0, obs}, 32'd0);
        check_counts("rst_async", 16'd0, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive("restart_miss", 1, 0, 0, 0, 0, 0, 0, 0, 18'd0);
        check_counts("restart", 16'd0, 16'd1);
        drive("restart_alloc",1, 0, 0, 0, 0, 0, 0, 1, v_alloc(1, 0));
        drive("restart_hit",  1, 0, 1, 0, 1, 0, 0, 0, v_hit(0, 0));
        check_counts("restart_done", 16'd1, 16'd1);

        // Hit counter saturation: 0x10000 hits in total since the reset.
        mem_read  = 1'b1;
        mem_write = 1'b0;
        hit       = 1'b1;
        hit_way   = 1'b0;
        pmem_resp = 1'b0;
        repeat (16'hFFFD) @(posedge clk);
        #1;
        check_counts("near_sat", 16'hFFFE, 16'd1);
        drive("sat_hit1",     1, 0, 1, 0, 0, 0, 0, 0, v_hit(0, 0));
        check_counts("sat", 16'hFFFF, 16'd1);
        drive("sat_hit2",     1, 0, 1, 0, 0, 0, 0, 0, v_hit(0, 0));
        check_counts("sat_hold", 16'hFFFF, 16'd1);

        mem_read = 1'b0;
        check_val("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
